load_store_unit: RTL and testbench

- Sits between the execute/memory pipeline stage and the word-addressed data memory (memData). It is directly upstream of the memory and drives its write/read address, data and write-enable.
- Turns RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into whole-word memory accesses.
- Performs read-modify-write for sub-word stores, and byte-lane extraction plus sign/zero extension for loads.
- Uses a valid/ready request and response handshake toward the pipeline.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_align.sv | 48 ++++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 tb/tb_load_store_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes,
// FSM state encoding and the access-size decode used by the datapath.
package lsu_pkg;

    // RV32I load/store funct3 codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Undefined funct3 codes fall through to a full-word access.
    function automatic size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: f3_size = SZ_B;
            F3_H, F3_HU: f3_size = SZ_H;
            default:     f3_size = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit: byte/halfword
// extraction with sign or zero extension for loads, and sub-word merge
// into a previously read word for stores. Halfword lanes use offset[1]
// only, so an odd halfword offset is naturally aligned down.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] merged
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        is_unsigned;

    assign lane_b      = word[{offset, 3'b000} +: 8];
    assign lane_h      = word[{offset[1], 4'b0000} +: 16];
    assign is_unsigned = funct3[2];

    // Load path: pick the addressed lane and extend it to XLEN
    always_comb begin
        rdata = word;
        case (f3_size(funct3))
            SZ_B: rdata = is_unsigned ? {{(XLEN-8){1'b0}}, lane_b}
                                      : {{(XLEN-8){lane_b[7]}}, lane_b};
            SZ_H: rdata = is_unsigned ? {{(XLEN-16){1'b0}}, lane_h}
                                      : {{(XLEN-16){lane_h[15]}}, lane_h};
            default: rdata = word;
        endcase
    end

    // Store path: overwrite only the target lane of the read word
    always_comb begin
        merged = word;
        case (f3_size(funct3))
            SZ_B: merged[{offset, 3'b000} +: 8]     = wdata[7:0];
            SZ_H: merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-addressed data memory.
// Sub-word stores are done as read-modify-write; loads extract and
// extend the addressed lane. Build option LSU_MISALIGN_CHECK_EN turns
// misaligned halfword/word accesses into an immediate flagged response
// that never touches memory; without it, low address bits are ignored
// down to natural alignment.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDRESSLEN = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDRESSLEN-1:0] req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [XLEN-1:0]       resp_rdata,
    output logic                  resp_misaligned,
    output logic [ADDRESSLEN-1:0] mem_write_address,
    output logic [ADDRESSLEN-1:0] mem_read_address,
    output logic [XLEN-1:0]       mem_data,
    output logic                  mem_write_enabled,
    input  logic [XLEN-1:0]       mem_out
);

    logic [1:0]            state;
    logic [ADDRESSLEN-1:0] lat_addr;
    logic [XLEN-1:0]       lat_wdata;
    logic [2:0]            lat_funct3;
    logic                  lat_write;
    logic [XLEN-1:0]       mem_data_r;
    logic [XLEN-1:0]       rdata_r;
    logic                  req_misaligned;
    logic [XLEN-1:0]       align_rdata;
    logic [XLEN-1:0]       align_merged;

    lsu_align #(.XLEN(XLEN)) u_align (
        .word   (mem_out),
        .offset (lat_addr[1:0]),
        .funct3 (lat_funct3),
        .wdata  (lat_wdata),
        .rdata  (align_rdata),
        .merged (align_merged)
    );

`ifdef LSU_MISALIGN_CHECK_EN
    logic misaligned_r;

    // Flag halfword accesses at odd addresses and words not on a 4-byte boundary
    always_comb begin
        req_misaligned = 1'b0;
        case (f3_size(req_funct3))
            SZ_H:    req_misaligned = req_addr[0];
            SZ_W:    req_misaligned = |req_addr[1:0];
            default: req_misaligned = 1'b0;
        endcase
    end

    // Misalignment flag is latched at accept and held through the response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misaligned_r <= 1'b0;
        end else if (state == ST_IDLE && req_valid) begin
            misaligned_r <= req_misaligned;
        end
    end

    assign resp_misaligned = misaligned_r;
`else
    assign req_misaligned  = 1'b0;
    assign resp_misaligned = 1'b0;
`endif

    // Control FSM plus request latches, merged store word and load result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_funct3 <= '0;
            lat_write  <= 1'b0;
            mem_data_r <= '0;
            rdata_r    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_addr   <= req_addr;
                        lat_wdata  <= req_wdata;
                        lat_funct3 <= req_funct3;
                        lat_write  <= req_write;
                        rdata_r    <= '0;
                        if (req_misaligned) begin
                            state <= ST_RESP;
                        end else if (!req_write) begin
                            state <= ST_READ;
                        end else if (f3_size(req_funct3) == SZ_W) begin
                            // Full-word store needs no read: data goes straight out
                            mem_data_r <= req_wdata;
                            state      <= ST_WRITE;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (lat_write) begin
                        mem_data_r <= align_merged;
                        state      <= ST_WRITE;
                    end else begin
                        rdata_r <= align_rdata;
                        state   <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    state <= ST_RESP;
                end
                default: begin
                    if (resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign req_ready         = (state == ST_IDLE);
    assign resp_valid        = (state == ST_RESP);
    assign resp_rdata        = rdata_r;
    assign mem_write_enabled = (state == ST_WRITE);
    assign mem_write_address = lat_addr;
    assign mem_read_address  = lat_addr;
    assign mem_data          = mem_data_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic [31:0] mem_write_address;
    logic [31:0] mem_read_address;
    logic [31:0] mem_data;
    logic        mem_write_enabled;
    logic [31:0] mem_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:31];
    int          wr_count = 0;
    logic [31:0] last_wdata = '0;

    load_store_unit #(.XLEN(32), .ADDRESSLEN(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_funct3        (req_funct3),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_rdata        (resp_rdata),
        .resp_misaligned   (resp_misaligned),
        .mem_write_address (mem_write_address),
        .mem_read_address  (mem_read_address),
        .mem_data          (mem_data),
        .mem_write_enabled (mem_write_enabled),
        .mem_out           (mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_out = mem[mem_read_address[6:2]];

    always @(posedge clk) begin
        if (mem_write_enabled) begin
            mem[mem_write_address[6:2]] <= mem_data;
            last_wdata <= mem_data;
            wr_count   <= wr_count + 1;
        end
    end

    // Issue one request, wait for its response, then handshake it.
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output int lat, output logic mis);
        @(negedge clk);
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        rd  = resp_rdata;
        mis = resp_misaligned;
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
        n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_resp_rdata got %h want 0", resp_rdata); end
        n_checks++; if (resp_misaligned !== 1'b0) begin n_fail++; $display("FAIL rst_misaligned got %b want 0", resp_misaligned); end
        n_checks++; if (mem_write_enabled !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b want 0", mem_write_enabled); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_sb();
        int wc0;
        @(negedge clk);
        req_write = 1'b1; req_funct3 = F3_B; req_addr = 32'hC; req_wdata = 32'h55; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        wc0 = wr_count;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", req_ready); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_async_idle got %b want 1", req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_after got %b want 1", req_ready); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (wr_count !== wc0) begin n_fail++; $display("FAIL mid_no_write got %0d want %0d", wr_count, wc0); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_resp got %b want 0", resp_valid); end
        n_checks++; if (mem[3] !== 32'h0) begin n_fail++; $display("FAIL mid_mem_untouched got %h want 0", mem[3]); end
    endtask

    task automatic test_loads();
        logic [31:0] rd;
        int          lat;
        logic        mis;
        logic [2:0]  f3s  [4] = '{F3_B, F3_B, F3_BU, F3_HU};
        logic [31:0] adrs [4] = '{32'h9, 32'hB, 32'hA, 32'hA};
        logic [31:0] exps [4] = '{32'h0000007F, 32'hFFFFFF80, 32'h000000FF, 32'h000080FF};
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, f3s[i], adrs[i], 32'h0, rd, lat, mis);
            n_checks++; if (rd !== exps[i]) begin n_fail++; $display("FAIL load%0d_data got %h want %h", i, rd, exps[i]); end
            n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL load%0d_latency got %0d want 2", i, lat); end
        end
    endtask

    task automatic test_sb();
        logic [31:0] rd;
        int          lat;
        int          wc0;
        logic        mis;
        wc0 = wr_count;
        do_req(1'b1, F3_B, 32'h6, 32'hAB, rd, lat, mis);
        n_checks++; if (wr_count - wc0 !== 1) begin n_fail++; $display("FAIL sb_writes got %0d want 1", wr_count - wc0); end
        n_checks++; if (last_wdata !== 32'h11AB3344) begin n_fail++; $display("FAIL sb_merge got %h want 11ab3344", last_wdata); end
        n_checks++; if (mem[1] !== 32'h11AB3344) begin n_fail++; $display("FAIL sb_mem got %h want 11ab3344", mem[1]); end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL sb_latency got %0d want 3", lat); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL sb_rdata got %h want 0", rd); end
    endtask

    task automatic test_sw_lw();
        logic [31:0] rd;
        int          lat;
        int          wc0;
        logic        mis;
        wc0 = wr_count;
        do_req(1'b1, F3_W, 32'h10, 32'hDEADBEEF, rd, lat, mis);
        n_checks++; if (wr_count - wc0 !== 1) begin n_fail++; $display("FAIL sw_writes got %0d want 1", wr_count - wc0); end
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sw_latency got %0d want 2", lat); end
        n_checks++; if (mem[4] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_mem got %h want deadbeef", mem[4]); end
        do_req(1'b0, F3_W, 32'h10, 32'h0, rd, lat, mis);
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data got %h want deadbeef", rd); end
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL lw_latency got %0d want 2", lat); end
        n_checks++; if (wr_count - wc0 !== 1) begin n_fail++; $display("FAIL lw_no_write got %0d want 1", wr_count - wc0); end
    endtask

    task automatic test_back_to_back();
        int waited;
        @(negedge clk);
        req_write = 1'b0; req_funct3 = F3_W; req_addr = 32'h8; req_wdata = 32'h0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        waited = 0;
        while (!resp_valid && waited < 20) begin @(posedge clk); #1 waited++; end
        n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL stall_resp_timeout got %b want 1", resp_valid); end
        @(negedge clk);
        req_funct3 = F3_B; req_addr = 32'h9; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL stall%0d_valid got %b want 1", i, resp_valid); end
            n_checks++; if (resp_rdata !== 32'h80FF7F01) begin n_fail++; $display("FAIL stall%0d_rdata got %h want 80ff7f01", i, resp_rdata); end
            n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL stall%0d_ready got %b want 0", i, req_ready); end
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle got %b want 1", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_resp_drop got %b want 0", resp_valid); end
        @(posedge clk);
        #1 req_valid = 1'b0;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept got %b want 0", req_ready); end
        @(posedge clk);
        #1;
        n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %b want 1", resp_valid); end
        n_checks++; if (resp_rdata !== 32'h0000007F) begin n_fail++; $display("FAIL b2b_rdata got %h want 0000007f", resp_rdata); end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic test_misalign();
        logic [31:0] rd;
        int          lat;
        int          wc0;
        logic        mis;
        wc0 = wr_count;
        do_req(1'b0, F3_W, 32'h5, 32'h0, rd, lat, mis);
`ifdef LSU_MISALIGN_CHECK_EN
        n_checks++; if (mis !== 1'b1) begin n_fail++; $display("FAIL mis_flag got %b want 1", mis); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mis_rdata got %h want 0", rd); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL mis_latency got %0d want 1", lat); end
`else
        n_checks++; if (mis !== 1'b0) begin n_fail++; $display("FAIL mis_flag got %b want 0", mis); end
        n_checks++; if (rd !== 32'h11AB3344) begin n_fail++; $display("FAIL mis_rdata got %h want 11ab3344", rd); end
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL mis_latency got %0d want 2", lat); end
`endif
        n_checks++; if (wr_count !== wc0) begin n_fail++; $display("FAIL mis_no_write got %0d want %0d", wr_count, wc0); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[1] = 32'h11223344;
        mem[2] = 32'h80FF7F01;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;
        test_reset();
        test_reset_mid_sb();
        test_loads();
        test_sb();
        test_sw_lw();
        test_back_to_back();
        test_misalign();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
